instr_exec_unit: RTL and testbench

Execution stage that sits directly downstream of the instruction register. On a start command it walks a contiguous range of register addresses by driving `read_pointer`, captures each `instruction_word`, and computes the opcode's result. It then presents the address, opcode and result on a valid/ready output port for the scoreboard or the writeback logic.

---
 rtl/instr_exec_unit.sv | 182 ++++++++++++++++++
 tb/tb_instr_exec_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_exec_unit.sv
// Purpose : walks a contiguous register range, fetches each instruction word and executes its opcode.
// Latency : start -> fetch next cycle, result valid 3 cycles after start; minimum 3 cycles per beat.
// Backpr. : OUT holds indefinitely while i_res_ready is low; all o_res_* outputs stay frozen.
module instr_exec_unit #(
    parameter int ADDR_W = 5,
    parameter int OP_W   = 32,
    parameter int RES_W  = 64
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_start,
    input  logic [ADDR_W-1:0]        i_start_addr,
    input  logic [ADDR_W:0]          i_count,
    output logic                     o_busy,
    output logic [ADDR_W-1:0]        o_read_pointer,
    input  logic [2:0]               i_instr_opc,
    input  logic signed [OP_W-1:0]   i_instr_operand_a,
    input  logic signed [OP_W-1:0]   i_instr_operand_b,
    output logic                     o_res_valid,
    input  logic                     i_res_ready,
    output logic [ADDR_W-1:0]        o_res_addr,
    output logic [2:0]               o_res_opc,
    output logic signed [RES_W-1:0]  o_res_data,
    output logic                     o_res_dz,
    output logic                     o_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_OUT   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [2:0] OPC_ZERO  = 3'd0;
    localparam logic [2:0] OPC_PASSA = 3'd1;
    localparam logic [2:0] OPC_PASSB = 3'd2;
    localparam logic [2:0] OPC_ADD   = 3'd3;
    localparam logic [2:0] OPC_SUB   = 3'd4;
    localparam logic [2:0] OPC_MULT  = 3'd5;
    localparam logic [2:0] OPC_DIV   = 3'd6;
    localparam logic [2:0] OPC_MOD   = 3'd7;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_t                   r_state;
    logic [ADDR_W-1:0]        r_addr;
    logic [ADDR_W:0]          r_remaining;
    logic [2:0]               r_opc;
    logic signed [OP_W-1:0]   r_op_a;
    logic signed [OP_W-1:0]   r_op_b;
    logic                     r_busy;
    logic [ADDR_W-1:0]        r_read_pointer;
    logic                     r_res_valid;
    logic [ADDR_W-1:0]        r_res_addr;
    logic [2:0]               r_res_opc;
    logic signed [RES_W-1:0]  r_res_data;
    logic                     r_res_dz;
    logic                     r_done;

    logic signed [RES_W-1:0]  w_a;
    logic signed [RES_W-1:0]  w_b;
    logic                     w_b_zero;
    logic signed [RES_W-1:0]  w_result;
    logic                     w_dz;
    logic [ADDR_W-1:0]        w_addr_next;

    // Operands are sign-extended to the result width so every opcode is exact.
    assign w_a         = {{(RES_W-OP_W){r_op_a[OP_W-1]}}, r_op_a};
    assign w_b         = {{(RES_W-OP_W){r_op_b[OP_W-1]}}, r_op_b};
    assign w_b_zero    = (r_op_b == '0);
    assign w_addr_next = r_addr + ADDR_ONE;   // wraps naturally at 2^ADDR_W

    // ALU on the captured instruction fields; divide/mod by zero yields 0 with the dz flag.
    always_comb begin
        w_result = '0;
        w_dz     = 1'b0;
        case (r_opc)
            OPC_ZERO:  w_result = '0;
            OPC_PASSA: w_result = w_a;
            OPC_PASSB: w_result = w_b;
            OPC_ADD:   w_result = w_a + w_b;
            OPC_SUB:   w_result = w_a - w_b;
            OPC_MULT:  w_result = w_a * w_b;
            OPC_DIV: begin
                if (w_b_zero) w_dz = 1'b1;
                else          w_result = w_a / w_b;
            end
            OPC_MOD: begin
                if (w_b_zero) w_dz = 1'b1;
                else          w_result = w_a % w_b;
            end
            default:   w_result = '0;
        endcase
    end

    // Scan controller: all outputs are registered and updated alongside the state.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state        <= S_IDLE;
            r_addr         <= '0;
            r_remaining    <= '0;
            r_opc          <= '0;
            r_op_a         <= '0;
            r_op_b         <= '0;
            r_busy         <= 1'b0;
            r_read_pointer <= '0;
            r_res_valid    <= 1'b0;
            r_res_addr     <= '0;
            r_res_opc      <= '0;
            r_res_data     <= '0;
            r_res_dz       <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_addr      <= i_start_addr;
                        r_remaining <= i_count;
                        r_busy      <= 1'b1;
                        if (i_count == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state        <= S_FETCH;
                            r_read_pointer <= i_start_addr;
                        end
                    end
                end
                S_FETCH: begin
                    // Register read path is combinational off o_read_pointer.
                    r_opc   <= i_instr_opc;
                    r_op_a  <= i_instr_operand_a;
                    r_op_b  <= i_instr_operand_b;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_res_addr  <= r_addr;
                    r_res_opc   <= r_opc;
                    r_res_data  <= w_result;
                    r_res_dz    <= w_dz;
                    r_res_valid <= 1'b1;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (i_res_ready) begin
                        r_res_valid <= 1'b0;
                        r_remaining <= r_remaining - REM_ONE;
                        r_addr      <= w_addr_next;
                        if (r_remaining > REM_ONE) begin
                            r_state        <= S_FETCH;
                            r_read_pointer <= w_addr_next;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy         = r_busy;
    assign o_read_pointer = r_read_pointer;
    assign o_res_valid    = r_res_valid;
    assign o_res_addr     = r_res_addr;
    assign o_res_opc      = r_res_opc;
    assign o_res_data     = r_res_data;
    assign o_res_dz       = r_res_dz;
    assign o_done         = r_done;

endmodule

// File: tb/tb_instr_exec_unit.sv
// Purpose : randomized scans of instr_exec_unit checked against an arithmetic reference model.
// Latency : checks exact cycle placement of fetch, result valid and done pulses.
// Backpr. : random res_ready stalls with stray start pulses; outputs must stay frozen.
module tb_instr_exec_unit;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               start;
    logic [4:0]         start_addr;
    logic [5:0]         count;
    logic               busy;
    logic [4:0]         read_pointer;
    logic [2:0]         instr_opc;
    logic signed [31:0] instr_operand_a;
    logic signed [31:0] instr_operand_b;
    logic               res_valid;
    logic               res_ready;
    logic [4:0]         res_addr;
    logic [2:0]         res_opc;
    logic signed [63:0] res_data;
    logic               res_dz;
    logic               done;

    // Instruction register contents, read combinationally through read_pointer.
    logic [2:0] mem_opc [32];
    int         mem_a   [32];
    int         mem_b   [32];

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] obs_data [$];
    bit          obs_dz   [$];
    int          obs_addr [$];

    always #5 clk = ~clk;

    assign instr_opc       = mem_opc[read_pointer];
    assign instr_operand_a = mem_a[read_pointer];
    assign instr_operand_b = mem_b[read_pointer];

    instr_exec_unit #(.ADDR_W(5), .OP_W(32), .RES_W(64)) dut (
        .i_clk             (clk),
        .i_reset_n         (reset_n),
        .i_start           (start),
        .i_start_addr      (start_addr),
        .i_count           (count),
        .o_busy            (busy),
        .o_read_pointer    (read_pointer),
        .i_instr_opc       (instr_opc),
        .i_instr_operand_a (instr_operand_a),
        .i_instr_operand_b (instr_operand_b),
        .o_res_valid       (res_valid),
        .i_res_ready       (res_ready),
        .o_res_addr        (res_addr),
        .o_res_opc         (res_opc),
        .o_res_data        (res_data),
        .o_res_dz          (res_dz),
        .o_done            (done)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arithmetic from the opcode definitions, using 64-bit signed integers.
    function automatic void ref_res(input logic [2:0] op, input int a, input int b,
                                    output longint r, output bit dz);
        longint la = a;
        longint lb = b;
        dz = 1'b0;
        r  = 0;
        case (op)
            3'd0: r = 0;
            3'd1: r = la;
            3'd2: r = lb;
            3'd3: r = la + lb;
            3'd4: r = la - lb;
            3'd5: r = la * lb;
            3'd6: if (b == 0) dz = 1'b1; else r = la / lb;
            3'd7: if (b == 0) dz = 1'b1; else r = la - (la / lb) * lb;
            default: r = 0;
        endcase
    endfunction

    function automatic int rand_operand();
        case ($urandom_range(0, 7))
            0: return 0;
            1: return 32'h7FFFFFFF;
            2: return int'(32'h80000000);
            3: return -1;
            default: return int'($urandom);
        endcase
    endfunction

    task automatic rand_mem();
        for (int i = 0; i < 32; i++) begin
            mem_opc[i] = 3'($urandom_range(0, 7));
            mem_a[i]   = rand_operand();
            mem_b[i]   = rand_operand();
        end
    endtask

    // One complete scan; first_stall >= 0 forces that stall on beat 0 and none later,
    // first_stall < 0 uses random stalls on every beat.
    task automatic run_scan(input int sa, input int cnt, input int first_stall);
        int     addr;
        int     stall;
        longint er;
        bit     edz;
        obs_data.delete();
        obs_dz.delete();
        obs_addr.delete();
        res_ready  = 1'b0;
        start_addr = 5'(sa);
        count      = 6'(cnt);
        start      = 1'b1;
        tick();
        start      = 1'b0;
        start_addr = 5'($urandom);
        count      = 6'($urandom);
        if (cnt == 0) begin
            check_eq("zc_done", done, 1);
            check_eq("zc_valid", res_valid, 0);
            check_eq("zc_busy", busy, 1);
            tick();
            check_eq("zc_done_low", done, 0);
            check_eq("zc_busy_low", busy, 0);
            check_eq("zc_valid_low", res_valid, 0);
            return;
        end
        for (int k = 0; k < cnt; k++) begin
            addr = (sa + k) % 32;
            ref_res(mem_opc[addr], mem_a[addr], mem_b[addr], er, edz);
            check_eq("fetch_ptr", read_pointer, addr);
            check_eq("fetch_valid", res_valid, 0);
            check_eq("fetch_done", done, 0);
            check_eq("fetch_busy", busy, 1);
            tick();
            check_eq("exec_valid", res_valid, 0);
            tick();
            check_eq("out_valid", res_valid, 1);
            check_eq("out_addr", res_addr, addr);
            check_eq("out_opc", res_opc, mem_opc[addr]);
            check_eq("out_data", res_data, er);
            check_eq("out_dz", res_dz, edz);
            obs_data.push_back(res_data);
            obs_dz.push_back(res_dz);
            obs_addr.push_back(int'(res_addr));
            if (first_stall >= 0) stall = (k == 0) ? first_stall : 0;
            else                  stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                start      = 1'($urandom_range(0, 1));
                start_addr = 5'($urandom);
                count      = 6'($urandom);
                tick();
                check_eq("stall_valid", res_valid, 1);
                check_eq("stall_addr", res_addr, addr);
                check_eq("stall_opc", res_opc, mem_opc[addr]);
                check_eq("stall_data", res_data, er);
                check_eq("stall_dz", res_dz, edz);
                check_eq("stall_done", done, 0);
            end
            start     = 1'b0;
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
        end
        check_eq("done_pulse", done, 1);
        check_eq("done_busy", busy, 1);
        check_eq("done_valid", res_valid, 0);
        tick();
        check_eq("done_low", done, 0);
        check_eq("idle_busy", busy, 0);
    endtask

    initial begin
        longint exp_ops [8];
        int     exp_wrap [4];
        exp_ops  = '{0, -7, 3, -4, -10, -21, -2, -1};
        exp_wrap = '{30, 31, 0, 1};
        rand_mem();
        reset_n    = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        count      = '0;
        res_ready  = 1'b0;

        // Reset values
        tick();
        tick();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_valid", res_valid, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_dz", res_dz, 0);
        check_eq("rst_ptr", read_pointer, 0);
        check_eq("rst_addr", res_addr, 0);
        check_eq("rst_opc", res_opc, 0);
        check_eq("rst_data", res_data, 0);
        reset_n = 1'b1;
        tick();

        // Reset while a beat is waiting in OUT
        start_addr = 5'd5;
        count      = 6'd3;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check_eq("mid_valid_pre", res_valid, 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_eq("mid_valid", res_valid, 0);
        check_eq("mid_busy", busy, 0);
        check_eq("mid_done", done, 0);
        for (int i = 0; i < 4; i++) begin
            res_ready = 1'b1;
            tick();
            check_eq("mid_no_done", done, 0);
            check_eq("mid_no_valid", res_valid, 0);
        end
        res_ready = 1'b0;

        // All opcodes with a = -7, b = 3
        for (int i = 0; i < 8; i++) begin
            mem_opc[i] = 3'(i);
            mem_a[i]   = -7;
            mem_b[i]   = 3;
        end
        run_scan(0, 8, 0);
        for (int i = 0; i < 8; i++) begin
            check_eq("op_const_data", obs_data[i], exp_ops[i]);
            check_eq("op_const_dz", obs_dz[i], 0);
        end

        // Divide/mod by zero and widest product
        mem_opc[10] = 3'd6; mem_a[10] = 9;            mem_b[10] = 0;
        mem_opc[11] = 3'd7; mem_a[11] = 9;            mem_b[11] = 0;
        mem_opc[12] = 3'd5; mem_a[12] = 32'h7FFFFFFF; mem_b[12] = 32'h7FFFFFFF;
        run_scan(10, 3, -1);
        check_eq("div0_data", obs_data[0], 0);
        check_eq("div0_dz", obs_dz[0], 1);
        check_eq("mod0_data", obs_data[1], 0);
        check_eq("mod0_dz", obs_dz[1], 1);
        check_eq("mult_wide", obs_data[2], 64'h3FFFFFFF00000001);
        check_eq("mult_dz", obs_dz[2], 0);

        // Address wrap-around
        rand_mem();
        run_scan(30, 4, -1);
        for (int i = 0; i < 4; i++) check_eq("wrap_addr", obs_addr[i], exp_wrap[i]);

        // Long stall on the first beat with stray start pulses
        run_scan($urandom_range(0, 31), 3, 5);

        // Zero count and single-entry latency
        run_scan(7, 0, -1);
        run_scan($urandom_range(0, 31), 1, 0);

        // Randomized scans, including full 32-entry sweeps
        for (int t = 0; t < 25; t++) begin
            rand_mem();
            run_scan($urandom_range(0, 31), (t % 8 == 7) ? 32 : $urandom_range(0, 32), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
